msx_ppi: RTL and testbench



---
 rtl/msx_ppi.sv | 112 +++++++++++
 tb/tb_msx_ppi.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/msx_ppi.sv
// Mode-0 subset of the i8255 PPI: slot select on port A, keyboard columns on port B,
// keyboard row / cassette / caps LED / click on port C.
module msx_ppi #(
    parameter logic [7:0] RESET_CTRL = 8'h9B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ppi_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic [1:0] addr,
    input  logic [7:0] d_from_cpu,
    output logic [7:0] d_to_cpu,
    input  logic [7:0] kb_cols,
    output logic [7:0] RAM_CS,
    output logic [3:0] kb_row,
    output logic       cas_motor_n,
    output logic       cas_out,
    output logic       caps_led,
    output logic       key_click
);

    logic [7:0] ctrl;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] c_q;
    logic [7:0] col_p0;
    logic [7:0] col_p1;
    logic       cs;
    logic       cs_q;
    logic       commit;
    logic       rd_en;
    logic [7:0] rd_data;
    logic [3:0] c_lo;
    logic [3:0] c_hi;
    logic       a_in;
    logic       b_in;
    logic       c_hi_in;
    logic       c_lo_in;
    logic [3:0] ctrl_unused;

    // Mode-select bits are kept for fidelity with the 8255 but only mode 0 exists here.
    assign ctrl_unused = {ctrl[7:5], ctrl[2]};

    assign a_in    = ctrl[4];
    assign b_in    = ctrl[1];
    assign c_hi_in = ctrl[3];
    assign c_lo_in = ctrl[0];

    assign cs     = ~ppi_n & ~wr_n;
    assign commit = cs & ~cs_q;
    assign rd_en  = ~ppi_n & ~rd_n & wr_n;

    always_comb begin
        RAM_CS      = a_in ? 8'hFF : a_q;
        c_lo        = c_lo_in ? 4'hF : c_q[3:0];
        c_hi        = c_hi_in ? 4'hF : c_q[7:4];
        kb_row      = c_lo;
        cas_motor_n = c_hi[0];
        cas_out     = c_hi[1];
        caps_led    = ~c_hi[2];
        key_click   = c_hi[3];
    end

    always_comb begin
        rd_data = 8'hFF;
        case (addr)
            2'd0:    rd_data = a_in ? 8'hFF : a_q;
            2'd1:    rd_data = b_in ? col_p1 : b_q;
            2'd2:    rd_data = {c_hi, c_lo};
            default: rd_data = 8'hFF;
        endcase
    end

    // cs_q resets high so a strobe already active when reset releases never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= RESET_CTRL;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            c_q      <= 8'h00;
            d_to_cpu <= 8'hFF;
            cs_q     <= 1'b1;
            col_p0   <= 8'hFF;
            col_p1   <= 8'hFF;
        end else begin
            cs_q   <= cs;
            col_p0 <= kb_cols;
            col_p1 <= col_p0;
            if (rd_en)
                d_to_cpu <= rd_data;
            if (commit) begin
                case (addr)
                    2'd0: a_q <= d_from_cpu;
                    2'd1: b_q <= d_from_cpu;
                    2'd2: c_q <= d_from_cpu;
                    default: begin
                        if (d_from_cpu[7]) begin
                            ctrl <= d_from_cpu;
                            a_q  <= 8'h00;
                            b_q  <= 8'h00;
                            c_q  <= 8'h00;
                        end else begin
                            c_q[d_from_cpu[3:1]] <= d_from_cpu[0];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msx_ppi.sv
// Directed table-driven bench for msx_ppi plus hand sequences for held strobes,
// column synchronisation and strobe-across-reset.
module tb_msx_ppi;

    logic       clk;
    logic       reset;
    logic       ppi_n;
    logic       wr_n;
    logic       rd_n;
    logic [1:0] addr;
    logic [7:0] d_from_cpu;
    logic [7:0] d_to_cpu;
    logic [7:0] kb_cols;
    logic [7:0] RAM_CS;
    logic [3:0] kb_row;
    logic       cas_motor_n;
    logic       cas_out;
    logic       caps_led;
    logic       key_click;

    int n_vec;
    int n_err;

    msx_ppi dut (
        .clk        (clk),
        .reset      (reset),
        .ppi_n      (ppi_n),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .addr       (addr),
        .d_from_cpu (d_from_cpu),
        .d_to_cpu   (d_to_cpu),
        .kb_cols    (kb_cols),
        .RAM_CS     (RAM_CS),
        .kb_row     (kb_row),
        .cas_motor_n(cas_motor_n),
        .cas_out    (cas_out),
        .caps_led   (caps_led),
        .key_click  (key_click)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_WR, K_RD, K_PA, K_PC, K_DO} kind_t;

    typedef struct {
        kind_t      kind;
        logic [1:0] a;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] pins_c();
        return {key_click, caps_led, cas_out, cas_motor_n, kb_row};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge.
    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        ppi_n = 1'b0; wr_n = 1'b0; addr = a; d_from_cpu = d;
        @(negedge clk);
        ppi_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [1:0] a);
        ppi_n = 1'b0; rd_n = 1'b0; addr = a;
        @(negedge clk);
        ppi_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic add(input kind_t k, input logic [1:0] a, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.kind = k; v.a = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; ppi_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        addr = 2'd0; d_from_cpu = 8'h00; kb_cols = 8'hFF;

        // pins_c byte = {key_click, caps_led, cas_out, cas_motor_n, kb_row}
        add(K_DO, 0, 0, 8'hFF);
        add(K_PA, 0, 0, 8'hFF);
        add(K_PC, 0, 0, 8'hBF);
        add(K_RD, 0, 0, 8'hFF);
        add(K_RD, 2, 0, 8'hFF);
        add(K_RD, 3, 0, 8'hFF);
        add(K_RD, 1, 0, 8'hFF);
        add(K_WR, 3, 8'h82, 0);
        add(K_PA, 0, 0, 8'h00);
        add(K_PC, 0, 0, 8'h40);
        add(K_WR, 0, 8'hF0, 0);
        add(K_PA, 0, 0, 8'hF0);
        add(K_RD, 0, 0, 8'hF0);
        add(K_WR, 3, 8'h0F, 0);
        add(K_PC, 0, 0, 8'hC0);
        add(K_WR, 3, 8'h0D, 0);
        add(K_PC, 0, 0, 8'h80);
        add(K_WR, 3, 8'h0C, 0);
        add(K_PC, 0, 0, 8'hC0);
        add(K_RD, 2, 0, 8'h80);
        add(K_WR, 2, 8'h05, 0);
        add(K_PC, 0, 0, 8'h45);
        add(K_RD, 2, 0, 8'h05);
        add(K_WR, 0, 8'h55, 0);
        add(K_PA, 0, 0, 8'h55);
        add(K_WR, 3, 8'h82, 0);
        add(K_PA, 0, 0, 8'h00);
        add(K_RD, 2, 0, 8'h00);
        add(K_WR, 3, 8'h80, 0);
        add(K_WR, 1, 8'hA5, 0);
        add(K_RD, 1, 0, 8'hA5);
        add(K_WR, 3, 8'h88, 0);
        add(K_WR, 2, 8'hA7, 0);
        add(K_PC, 0, 0, 8'hB7);
        add(K_RD, 2, 0, 8'hF7);
        add(K_WR, 3, 8'h82, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_WR: cpu_write(vecs[i].a, vecs[i].data);
                K_RD: begin
                    cpu_read(vecs[i].a);
                    check($sformatf("vec%0d read addr%0d", i, vecs[i].a), d_to_cpu, vecs[i].exp);
                end
                K_PA: check($sformatf("vec%0d RAM_CS", i), RAM_CS, vecs[i].exp);
                K_PC: check($sformatf("vec%0d port C pins", i), pins_c(), vecs[i].exp);
                default: check($sformatf("vec%0d d_to_cpu", i), d_to_cpu, vecs[i].exp);
            endcase
        end

        // Column synchroniser: ctrl=82h, B is input.
        ppi_n = 1'b0; rd_n = 1'b0; addr = 2'd1;
        @(negedge clk);
        check("kb_cols idle", d_to_cpu, 8'hFF);
        kb_cols = 8'hFE;
        @(negedge clk);
        check("kb_cols not yet synced", d_to_cpu, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        check("kb_cols synced", d_to_cpu, 8'hFE);
        ppi_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        kb_cols = 8'hFF;
        check("read data held", d_to_cpu, 8'hFE);

        // Held strobe with data changing mid-strobe commits once with the first data.
        ppi_n = 1'b0; wr_n = 1'b0; addr = 2'd2; d_from_cpu = 8'h05;
        repeat (5) @(negedge clk);
        d_from_cpu = 8'h07;
        repeat (5) @(negedge clk);
        ppi_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check("held strobe kb_row", {4'h0, kb_row}, 8'h05);
        cpu_read(2'd2);
        check("held strobe C", d_to_cpu, 8'h05);

        // Write strobe active across reset release: a mode set to 80h must not land.
        ppi_n = 1'b0; wr_n = 1'b0; addr = 2'd3; d_from_cpu = 8'h80;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        ppi_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check("strobe over reset RAM_CS", RAM_CS, 8'hFF);
        check("strobe over reset port C", pins_c(), 8'hBF);
        cpu_write(2'd3, 8'h82);
        check("post-reset latch A", RAM_CS, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
